// File: rtl/fir_coeff_ctrl.sv
// Coefficient-load and sequencing controller for the FIR filter family.
// Loads a serial coefficient stream into a shadow bank, drains the filter, then swaps banks atomically.
module fir_coeff_ctrl #(
  parameter int NUM_TAPS     = 100,
  parameter int COEFF_W      = 32,
  parameter int FLUSH_CYCLES = NUM_TAPS + 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic signed [COEFF_W-1:0] cfg_data,
  input  logic                      cfg_last,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      fir_valid,
  output logic signed [COEFF_W-1:0] coeffs [NUM_TAPS-1:0],
  output logic                      active_valid,
  output logic [7:0]                coeff_gen,
  output logic                      busy,
  output logic                      err_len,
  input  logic                      err_clr
);

  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,
    S_RUN   = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_SWAP  = 3'd4
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          wr_idx_r;
  logic [CNT_W-1:0]          drain_cnt_r;
  logic signed [COEFF_W-1:0] shadow_r [NUM_TAPS-1:0];
  logic                      accept_s;
  logic                      len_ok_s;
  logic                      len_err_s;

  // Handshake and gating decode from the registered state.
  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state_r)
      S_EMPTY: begin
        cfg_ready = 1'b1;
      end
      S_RUN: begin
        cfg_ready = 1'b1;
        in_ready  = 1'b1;
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        in_ready  = active_valid;
        busy      = 1'b1;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_SWAP: begin
        busy = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
      end
    endcase
    fir_valid = in_valid & in_ready;
    accept_s  = cfg_valid & cfg_ready;
    // A load is good only when the last word lands exactly on the final tap.
    len_ok_s  = accept_s & cfg_last & (wr_idx_r == LAST_IDX);
    len_err_s = accept_s & ~len_ok_s & (cfg_last | (wr_idx_r == LAST_IDX));
  end

  // Shadow bank capture; contents are meaningless until a full load completes.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      shadow_r[wr_idx_r] <= cfg_data;
    end
  end

  // Load/drain/swap sequencing and the active bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_EMPTY;
      wr_idx_r     <= {IDX_W{1'b0}};
      drain_cnt_r  <= {CNT_W{1'b0}};
      active_valid <= 1'b0;
      coeff_gen    <= 8'd0;
      err_len      <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coeffs[i] <= {COEFF_W{1'b0}};
      end
    end else begin
      if (len_err_s) begin
        err_len <= 1'b1;
      end else if (err_clr) begin
        err_len <= 1'b0;
      end

      case (state_r)
        S_EMPTY, S_RUN, S_LOAD: begin
          if (len_ok_s) begin
            state_r     <= S_DRAIN;
            drain_cnt_r <= DRAIN_INIT;
            wr_idx_r    <= {IDX_W{1'b0}};
          end else if (len_err_s) begin
            state_r  <= active_valid ? S_RUN : S_EMPTY;
            wr_idx_r <= {IDX_W{1'b0}};
          end else if (accept_s) begin
            state_r  <= S_LOAD;
            wr_idx_r <= wr_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        S_DRAIN: begin
          if (drain_cnt_r == {CNT_W{1'b0}}) begin
            state_r <= S_SWAP;
          end else begin
            drain_cnt_r <= drain_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_SWAP: begin
          for (int i = 0; i < NUM_TAPS; i++) begin
            coeffs[i] <= shadow_r[i];
          end
          active_valid <= 1'b1;
          coeff_gen    <= coeff_gen + 8'd1;
          state_r      <= S_RUN;
        end
        default: begin
          state_r <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: a transaction-level model compared every cycle,
// plus directed loads with hand-computed expectations.
module tb_fir_coeff_ctrl;

  localparam int NT = 4;
  localparam int FC = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic signed [31:0] cfg_data = 32'sd0;
  logic               cfg_last = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               fir_valid;
  logic signed [31:0] coeffs [NT-1:0];
  logic               active_valid;
  logic [7:0]         coeff_gen;
  logic               busy;
  logic               err_len;
  logic               err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  fir_coeff_ctrl #(.NUM_TAPS(NT), .COEFF_W(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .in_valid(in_valid), .in_ready(in_ready), .fir_valid(fir_valid),
    .coeffs(coeffs), .active_valid(active_valid), .coeff_gen(coeff_gen),
    .busy(busy), .err_len(err_len), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending word list, a blackout window after a good load, and the swap at its end.
  logic signed [31:0] q [$];
  logic signed [31:0] m_active [NT];
  logic signed [31:0] m_pending [NT];
  int                 m_blackout = 0;
  bit                 m_act_valid = 1'b0;
  int                 m_gen = 0;
  bit                 m_err = 1'b0;
  bit                 m_acc, m_err_set;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_blackout  = 0;
      m_act_valid = 1'b0;
      m_gen       = 0;
      m_err       = 1'b0;
      for (int i = 0; i < NT; i++) m_active[i] = 32'sd0;
    end else begin
      m_err_set = 1'b0;
      m_acc = cfg_valid && (m_blackout == 0);
      if (m_blackout > 0) begin
        m_blackout--;
        if (m_blackout == 0) begin
          for (int i = 0; i < NT; i++) m_active[i] = m_pending[i];
          m_act_valid = 1'b1;
          m_gen = (m_gen + 1) % 256;
        end
      end else if (m_acc) begin
        q.push_back(cfg_data);
        if (cfg_last) begin
          if (q.size() == NT) begin
            for (int i = 0; i < NT; i++) m_pending[i] = q[i];
            m_blackout = FC + 1;
          end else begin
            m_err_set = 1'b1;
          end
          q.delete();
        end else if (q.size() == NT) begin
          m_err_set = 1'b1;
          q.delete();
        end
      end
      if (m_err_set) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cfg_ready", 32'(cfg_ready), 32'(m_blackout == 0));
      check("in_ready", 32'(in_ready), 32'((m_blackout == 0) && m_act_valid));
      check("fir_valid", 32'(fir_valid), 32'(in_valid && (m_blackout == 0) && m_act_valid));
      check("busy", 32'(busy), 32'((m_blackout > 0) || (q.size() > 0)));
      check("active_valid", 32'(active_valid), 32'(m_act_valid));
      check("coeff_gen", 32'(coeff_gen), 32'(m_gen));
      check("err_len", 32'(err_len), 32'(m_err));
      for (int i = 0; i < NT; i++) check("coeffs", coeffs[i], m_active[i]);
    end
  end

  int zero_cnt = 0;
  bit count_en = 1'b0;
  always @(negedge clk) begin
    if (count_en && !fir_valid) zero_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic signed [31:0] d, input logic last, input int gap);
    bit done = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    for (int n = 0; n < 50 && !done; n++) begin
      done = cfg_ready;
      tick(1);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout actual=not_accepted expected=accepted");
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    tick(gap);
  endtask

  task automatic load4(input int a, input int b, input int c, input int d, input int gap);
    send_word(32'(a), 1'b0, gap);
    send_word(32'(b), 1'b0, gap);
    send_word(32'(c), 1'b0, gap);
    send_word(32'(d), 1'b1, 0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick(1);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // 1: reset state
    tick(3);
    rst_n = 1'b1;
    in_valid = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'd0);
    check("t1_fir_valid", 32'(fir_valid), 32'd0);
    check("t1_cfg_ready", 32'(cfg_ready), 32'd1);
    check("t1_coeff_gen", 32'(coeff_gen), 32'd0);
    for (int i = 0; i < NT; i++) check("t1_coeffs", coeffs[i], 32'd0);
    tick(1);

    // 2: first load from EMPTY, back to back
    load4(10, 20, 30, 40, 0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_idle(n);
    check("t2_blackout_len", 32'(n), 32'd4);
    check("t2_c0", coeffs[0], 32'sd10);
    check("t2_c1", coeffs[1], 32'sd20);
    check("t2_c2", coeffs[2], 32'sd30);
    check("t2_c3", coeffs[3], 32'sd40);
    check("t2_active_valid", 32'(active_valid), 32'd1);
    check("t2_gen", 32'(coeff_gen), 32'd1);
    check("t2_fir_valid", 32'(fir_valid), 32'd1);

    // 3: reload while running, one idle cycle between words
    zero_cnt = 0;
    count_en = 1'b1;
    load4(-1, -2, -3, -4, 1);
    wait_idle(n);
    tick(3);
    count_en = 1'b0;
    check("t3_fir_valid_gap", 32'(zero_cnt), 32'd4);
    check("t3_c0", coeffs[0], -32'sd1);
    check("t3_c3", coeffs[3], -32'sd4);
    check("t3_gen", 32'(coeff_gen), 32'd2);

    // 4: short load, error clear, then a good load
    send_word(32'sd5, 1'b0, 0);
    send_word(32'sd6, 1'b0, 0);
    send_word(32'sd7, 1'b1, 0);
    check("t4_err_len", 32'(err_len), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_c0_kept", coeffs[0], -32'sd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_err_cleared", 32'(err_len), 32'd0);
    load4(5, 6, 7, 8, 0);
    wait_idle(n);
    check("t4_c3", coeffs[3], 32'sd8);
    check("t4_gen", 32'(coeff_gen), 32'd3);

    // 5: four words without last, then a good load
    send_word(32'sd9, 1'b0, 0);
    send_word(32'sd10, 1'b0, 0);
    send_word(32'sd11, 1'b0, 0);
    send_word(32'sd12, 1'b0, 0);
    check("t5_err_len", 32'(err_len), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_c0_kept", coeffs[0], 32'sd5);
    load4(1, 2, 3, 4, 0);
    wait_idle(n);
    check("t5_c0", coeffs[0], 32'sd1);
    check("t5_c3", coeffs[3], 32'sd4);
    check("t5_gen", 32'(coeff_gen), 32'd4);

    // 6: reset while draining
    load4(70, 71, 72, 73, 0);
    tick(1);
    check("t6_in_drain", 32'(cfg_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_c1", coeffs[1], 32'sd0);
    check("t6_active_valid", 32'(active_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_gen", 32'(coeff_gen), 32'd0);
    check("t6_err_len", 32'(err_len), 32'd0);
    tick(2);
    rst_n = 1'b1;
    #1;
    check("t6_cfg_ready", 32'(cfg_ready), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_fir_valid", 32'(fir_valid), 32'd0);

    // 7: 256 good loads wrap the generation counter
    for (int k = 0; k < 256; k++) begin
      load4(k, k + 1, k + 2, k + 3, 0);
      wait_idle(n);
      if (k == 254) check("t7_gen_255", 32'(coeff_gen), 32'd255);
    end
    check("t7_gen_wrap", 32'(coeff_gen), 32'd0);
    check("t7_model_gen_wrap", 32'(m_gen), 32'd0);
    check("t7_c0", coeffs[0], 32'sd255);
    check("t7_c3", coeffs[3], 32'sd258);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Coefficient-load and sequencing controller for the FIR filter family (fir_pipeline, fir_parallel_L2/L3, fir_parallel_L3_pipeline).
- Accepts a serial coefficient stream into a shadow bank.
- Drains the filter pipeline, then atomically swaps the shadow bank into the active coeffs array driven onto the filter.
- Gates the filter's valid so that no sample is processed with a mixed or undefined coefficient set.
- Sits between the sample source/config master and the filter instance in top.

Parameters:
- NUM_TAPS, 100: number of coefficients; sizes both banks.
- COEFF_W, 32: coefficient width, signed.
- FLUSH_CYCLES, NUM_TAPS+4: cycles valid is held low before a swap. Must be ≥1 and ≥ worst-case filter latency.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  controller can accept a coefficient word.
- cfg_data  in  COEFF_W  signed coefficient. Word k of a load goes to tap k; word 0 is sent first.
- cfg_last  in  1  marks the final word of a load.
- in_valid  in  1  sample source has a sample/vector this cycle.
- in_ready  out  1  controller allows samples into the filter.
- fir_valid  out  1  valid to the filter, equal to in_valid & in_ready.
- coeffs  out  COEFF_W x NUM_TAPS (unpacked array [NUM_TAPS-1:0])  active bank to the filter.
- active_valid  out  1  an active bank has been installed since reset.
- coeff_gen  out  8  count of completed swaps; wraps 255 -> 0.
- busy  out  1  high in LOAD, DRAIN and SWAP.
- err_len  out  1  sticky load-length error.
- err_clr  in  1  synchronous clear of err_len.

Behaviour:
- Reset (async assert, sync release): state = EMPTY; coeffs all 0; active_valid, coeff_gen, err_len, wr_idx (load index) and drain_cnt all 0. The shadow bank is not reset.
- States:
  - EMPTY: no active bank.
  - RUN: active bank in use, filter running.
  - LOAD: shadow bank being written.
  - DRAIN: filter pipeline emptying.
  - SWAP: shadow copied to active.
- cfg_ready = 1 in EMPTY, RUN and LOAD; 0 in DRAIN and SWAP. A word is accepted on cfg_valid & cfg_ready, writes shadow[wr_idx], then wr_idx increments.
- EMPTY/RUN -> LOAD on the first accepted word.
  - If that word is also cfg_last: with NUM_TAPS = 1 it is a valid load and goes straight to DRAIN; otherwise it is a length error (see next bullet).
- LOAD, accepted word, length check:
  - cfg_last with wr_idx == NUM_TAPS-1: go to DRAIN, load drain_cnt = FLUSH_CYCLES-1, reset wr_idx to 0.
  - cfg_last with wr_idx < NUM_TAPS-1, or wr_idx == NUM_TAPS-1 without cfg_last: length error.
- Length error (on the erroring word's cycle):
  - err_len <= 1; wr_idx <= 0; shadow discarded.
  - Next state is RUN if active_valid, else EMPTY. Active coeffs are untouched.
- in_ready = 1 in RUN, and in LOAD when active_valid = 1; otherwise 0. The filter keeps running on the old bank while a new one loads.
- DRAIN: in_ready = 0, so fir_valid = 0. drain_cnt decrements each cycle; at 0, next state is SWAP. Total time in DRAIN is exactly FLUSH_CYCLES cycles.
- SWAP: one cycle. in_ready = 0. coeffs <= shadow (all taps same edge); active_valid <= 1; coeff_gen <= coeff_gen+1. Next state is RUN.
- fir_valid is combinational from in_valid and the registered state. No added latency on the sample path.
- err_clr: clears err_len. If a new error occurs in the same cycle, the set wins.
- cfg_valid with cfg_ready = 0: word not accepted; the master holds it (standard valid/ready, no drop).
- Reset mid-LOAD/DRAIN: returns to EMPTY, active_valid = 0, coeffs = 0. A new full load is required before samples flow.
- busy = 1 in LOAD, DRAIN and SWAP.

Test Plan:
Bench configuration: NUM_TAPS = 4, FLUSH_CYCLES = 3, COEFF_W = 32.
1. Reset, then in_valid = 1 held -> in_ready = 0, fir_valid = 0, coeffs = {0,0,0,0}, cfg_ready = 1, coeff_gen = 0.
2. Load 10,20,30,40 (last on 40) back-to-back from EMPTY -> busy = 1; DRAIN for 3 cycles; 1 SWAP cycle. Then coeffs[0..3] = 10,20,30,40, active_valid = 1, coeff_gen = 1, fir_valid follows in_valid from the next cycle.
3. In RUN with in_valid = 1, load -1,-2,-3,-4 with one idle cycle between words -> fir_valid stays 1 through LOAD with coeffs still 10..40. fir_valid = 0 for exactly 4 cycles (3 DRAIN + 1 SWAP). Then coeffs = -1..-4, coeff_gen = 2.
4. In RUN, send 3 words with cfg_last on the third -> err_len = 1, state back to RUN, coeffs unchanged, in_ready = 1. err_clr = 1 for one cycle -> err_len = 0. A following correct 4-word load succeeds.
5. Send 4 words with no cfg_last -> err_len = 1 on the fourth word, wr_idx = 0. The next 4-word load with last on word 4 swaps correctly.
6. Assert rst_n = 0 during DRAIN -> immediately coeffs = 0, active_valid = 0, in_ready = 0, coeff_gen = 0. After release, state is EMPTY and cfg_ready = 1.
7. Perform 256 successful loads -> coeff_gen wraps to 0.
